// File: rtl/digit_scanner.sv
// digit_scanner: time-multiplexes four hex digits onto a one-hot anode bus with
// anti-ghost blanking, tear-free value updates and leading-zero suppression.
module digit_scanner #(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        lz_en,
   output logic [3:0]  binary,
   output logic [3:0]  an,
   output logic        frame_done
);
   localparam int CW = $clog2(CLK_DIV);
   typedef enum logic [1:0] {OFF, SHOW, GAP} state_t;
   state_t state, nxt_state;
   logic [15:0] pending, shown, nxt_shown;
   logic [1:0] idx, nxt_idx;
   logic [CW-1:0] cnt, nxt_cnt;
   logic advance, wrap, boundary, lit;
   logic [3:0] nxt_digit;
   // outputs are registered from the next-state values so they line up with state
   always_comb begin
      advance   = (state == SHOW && cnt == '0 && BLANK_CYCLES == 0) || (state == GAP && cnt == '0);
      wrap      = enable && advance && idx == 2'd3;
      boundary  = enable && (wrap || state == OFF);
      nxt_shown = boundary ? (load ? value : pending) : shown;
      nxt_state = !enable ? OFF :
                  state == OFF ? SHOW :
                  (state == SHOW && cnt == '0 && BLANK_CYCLES > 0) ? GAP :
                  (state == GAP && cnt == '0) ? SHOW : state;
      nxt_idx   = (!enable || state == OFF) ? 2'd0 : advance ? idx + 2'd1 : idx;
      nxt_cnt   = !enable ? '0 :
                  (state == OFF || advance) ? CW'(CLK_DIV - 1) :
                  cnt != '0 ? cnt - CW'(1) : CW'(BLANK_CYCLES - 1);
      nxt_digit = nxt_shown[{nxt_idx, 2'b00} +: 4];
      lit       = !lz_en || nxt_idx == 2'd0 || (nxt_shown >> {nxt_idx, 2'b00}) != 16'd0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= OFF;
         idx        <= 2'd0;
         cnt        <= '0;
         pending    <= 16'd0;
         shown      <= 16'd0;
         an         <= 4'd0;
         binary     <= 4'd0;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt_state;
         idx        <= nxt_idx;
         cnt        <= nxt_cnt;
         pending    <= load ? value : pending;
         shown      <= nxt_shown;
         an         <= (nxt_state == SHOW && lit) ? 4'b0001 << nxt_idx : 4'd0;
         binary     <= nxt_state == SHOW ? nxt_digit : nxt_state == GAP ? binary : 4'd0;
         frame_done <= wrap;
      end
   end
endmodule

// File: tb/tb_digit_scanner.sv
// tb_digit_scanner: drives a blanking and a gapless scanner with the same stimulus
// and compares both against a frame-position model of the display.
module tb_digit_scanner;
   localparam int CD = 4;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, load = 1'b0, lz_en = 1'b0;
   logic [15:0] value = 16'd0;
   logic [3:0] binary [2];
   logic [3:0] an [2];
   logic frame_done [2];
   int n_tests = 0, n_fail = 0;
   int p [2];
   bit on [2];
   logic [15:0] frame [2];
   logic [15:0] pend;

   always #5 clk = ~clk;

   digit_scanner #(.CLK_DIV(CD), .BLANK_CYCLES(1)) u_gap (
      .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .load(load), .lz_en(lz_en),
      .binary(binary[0]), .an(an[0]), .frame_done(frame_done[0]));
   digit_scanner #(.CLK_DIV(CD), .BLANK_CYCLES(0)) u_nogap (
      .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .load(load), .lz_en(lz_en),
      .binary(binary[1]), .an(an[1]), .frame_done(frame_done[1]));

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // model: position p within the scan decides digit and lit/dark slot
   task automatic cyc();
      int pp, d;
      bit slot, lit;
      logic [15:0] f;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         pp = CD + (k == 0 ? 1 : 0);
         if (!rst_n) begin
            on[k] = 1'b0; p[k] = 0; frame[k] = 16'd0;
         end else if (!enable) on[k] = 1'b0;
         else if (!on[k]) begin
            on[k] = 1'b1; p[k] = 0; frame[k] = load ? value : pend;
         end else begin
            p[k]++;
            if (p[k] % (4 * pp) == 0) frame[k] = load ? value : pend;
         end
      end
      pend = !rst_n ? 16'd0 : load ? value : pend;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         pp = CD + (k == 0 ? 1 : 0);
         d = (p[k] / pp) % 4;
         slot = (p[k] % pp) < CD;
         f = frame[k];
         lit = !lz_en || d == 0 || (f >> (4 * d)) != 16'd0;
         chk($sformatf("an%0d", k), an[k], (on[k] && slot && lit) ? 4'(1 << d) : 4'd0);
         chk($sformatf("binary%0d", k), binary[k], on[k] ? f[4 * d +: 4] : 4'd0);
         chk($sformatf("frame_done%0d", k), frame_done[k],
             (on[k] && p[k] > 0 && p[k] % (4 * pp) == 0) ? 1'b1 : 1'b0);
         chk($sformatf("onehot%0d", k), $onehot0(an[k]), 1'b1);
      end
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic ld(input logic [15:0] v);
      value = v; load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   initial begin
      pend = 16'd0;
      for (int k = 0; k < 2; k++) begin on[k] = 1'b0; p[k] = 0; frame[k] = 16'd0; end
      enable = 1'b1; load = 1'b1; value = 16'hFFFF;
      run(3);
      rst_n = 1'b1;
      ld(16'h1234);
      run(44);
      ld(16'hABCD);
      run(3);
      ld(16'h5678);
      run(50);
      lz_en = 1'b1;
      ld(16'h0040);
      run(45);
      ld(16'h0000);
      run(45);
      lz_en = 1'b0;
      run(25);
      ld(16'h1234);
      run(10);
      enable = 1'b0;
      run(3);
      enable = 1'b1;
      run(25);
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      ld(16'h9E07);
      run(40);
      for (int i = 0; i < 2000; i++) begin
         rst_n  = $urandom_range(99) != 0;
         enable = $urandom_range(39) != 0;
         load   = $urandom_range(14) == 0;
         value  = 16'($urandom) >> (4 * $urandom_range(4));
         if ($urandom_range(49) == 0) lz_en = ~lz_en;
         cyc();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
